aes_inv_key_sched: RTL and testbench

//  Word-serial AES key schedule for the decryption datapath. Round keys come out in reverse order (Nr..0) over a valid/ready stream.
//  The block latches the cipher key, runs the schedule forward to the last NK words, then inverts the recurrence one word per cycle.

---
 rtl/aes_inv_key_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_aes_inv_key_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_sched.sv
// rtl/aes_inv_key_sched.sv - word-serial AES key schedule emitting round keys NR..0 over valid/ready
// Optional feature macro AES_EQ_INV_KEY_EN: InvMixColumns on rounds 1..NR-1 (equivalent inverse cipher).

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = x;
    for (int k = 0; k < 8; k++) begin
      if (z[k]) acc = acc ^ p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] inv;
  logic [7:0] pw;

  // Multiplicative inverse as a^254 (maps 0 to 0), followed by the affine transform.
  always_comb begin
    inv = 8'h01;
    pw  = a;
    for (int k = 1; k < 8; k++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
  end

  assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_inv_key_sched #(
  parameter int NK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [32*NK-1:0]  key_in,
  output logic              busy,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [127:0]      rk_out,
  output logic [3:0]        rk_round,
  output logic              done
);
  localparam int NR      = NK + 6;
  localparam int NW      = 4 * (NR + 1);
  localparam int FWD_END = NW - NK;

  typedef enum logic [1:0] {IDLE, FWD, BWD} state_t;

  state_t       state, state_n;
  logic [31:0]  win   [NK];
  logic [31:0]  win_n [NK];
  logic [7:0]   b, b_n;
  logic [3:0]   r, r_n;
  logic         busy_n, valid_n;
  logic [127:0] rk_q, rk_n, sel;
  logic [7:0]   off;

  logic [7:0]   idx;
  logic         idx_mod0, idx_mod4;
  logic [31:0]  t_in, sub_in, sub_out, t_word, new_fwd, new_bwd;

  function automatic logic [7:0] rcon(input logic [7:0] n);
    case (n)
      8'd1:    return 8'h01;
      8'd2:    return 8'h02;
      8'd3:    return 8'h04;
      8'd4:    return 8'h08;
      8'd5:    return 8'h10;
      8'd6:    return 8'h20;
      8'd7:    return 8'h40;
      8'd8:    return 8'h80;
      8'd9:    return 8'h1b;
      8'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic in_win(input logic [3:0] rr, input logic [7:0] bb);
    logic [7:0] lo;
    lo = {2'b00, rr, 2'b00};
    return (lo >= bb) && (lo + 8'd3 <= bb + 8'(NK - 1));
  endfunction

  // One recurrence term per cycle; forward uses index b+NK, backward index b+NK-1.
  assign idx      = (state == FWD) ? b + 8'(NK) : b + 8'(NK - 1);
  assign t_in     = (state == FWD) ? win[NK-1] : win[NK-2];
  assign idx_mod0 = (idx % 8'(NK)) == 8'd0;
  assign idx_mod4 = (idx % 8'(NK)) == 8'd4;
  assign sub_in   = idx_mod0 ? {t_in[23:0], t_in[31:24]} : t_in;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sub_in[8*g +: 8]),
      .y (sub_out[8*g +: 8])
    );
  end

  assign t_word  = idx_mod0 ? (sub_out ^ {rcon(idx / 8'(NK)), 24'h000000})
                 : ((NK == 8) && idx_mod4) ? sub_out : t_in;
  assign new_fwd = win[0] ^ t_word;
  assign new_bwd = win[NK-1] ^ t_word;

  always_comb begin
    state_n = state;
    win_n   = win;
    b_n     = b;
    r_n     = r;
    busy_n  = busy;
    valid_n = rk_valid;
    case (state)
      IDLE: begin
        if (start) begin
          for (int k = 0; k < NK; k++) win_n[k] = key_in[32*(NK-k)-1 -: 32];
          b_n     = 8'd0;
          r_n     = 4'(NR);
          busy_n  = 1'b1;
          valid_n = 1'b0;
          state_n = FWD;
        end
      end
      FWD: begin
        for (int k = 0; k < NK - 1; k++) win_n[k] = win[k+1];
        win_n[NK-1] = new_fwd;
        b_n         = b + 8'd1;
        if (b_n == 8'(FWD_END)) begin
          r_n     = 4'(NR);
          valid_n = 1'b1;
          state_n = BWD;
        end
      end
      BWD: begin
        if (rk_valid) begin
          if (rk_ready) begin
            if (r == 4'd0) begin
              valid_n = 1'b0;
              busy_n  = 1'b0;
              state_n = IDLE;
            end else begin
              r_n     = r - 4'd1;
              valid_n = in_win(r - 4'd1, b);
            end
          end
        end else begin
          win_n[0] = new_bwd;
          for (int k = 1; k < NK; k++) win_n[k] = win[k-1];
          b_n     = b - 8'd1;
          valid_n = in_win(r, b - 8'd1);
        end
      end
      default: state_n = IDLE;
    endcase

    off = {2'b00, r_n, 2'b00} - b_n;
    sel = rk_q;
    for (int j = 0; j <= NK - 4; j++) begin
      if (off == 8'(j)) sel = {win_n[j], win_n[j+1], win_n[j+2], win_n[j+3]};
    end
    rk_n = valid_n ? sel : rk_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      for (int k = 0; k < NK; k++) win[k] <= 32'h0;
      b        <= 8'd0;
      r        <= 4'd0;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_q     <= 128'h0;
    end else begin
      state    <= state_n;
      win      <= win_n;
      b        <= b_n;
      r        <= r_n;
      busy     <= busy_n;
      rk_valid <= valid_n;
      rk_q     <= rk_n;
    end
  end

  assign done     = (state == BWD) && rk_valid && rk_ready && (r == 4'd0);
  assign rk_round = r;

`ifdef AES_EQ_INV_KEY_EN
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] x);
    return xt(xt(xt(x))) ^ x;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(x) ^ x;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
            mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
            mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3),
            mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3)};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] k);
    return {inv_mix_col(k[127:96]), inv_mix_col(k[95:64]),
            inv_mix_col(k[63:32]), inv_mix_col(k[31:0])};
  endfunction

  // First and last round keys feed AddRoundKey directly and stay raw.
  assign rk_out = ((r != 4'd0) && (r != 4'(NR))) ? inv_mix(rk_q) : rk_q;
`else
  assign rk_out = rk_q;
`endif
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb/tb_aes_inv_key_sched.sv - scoreboard bench for aes_inv_key_sched at NK=4, 6 and 8
// Honours AES_EQ_INV_KEY_EN when expected round keys are built.

module tb_aes_inv_key_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, rk_ready;
  logic         start4, start6, start8;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic         busy4, busy6, busy8, valid4, valid6, valid8, done4, done6, done8;
  logic [127:0] out4, out6, out8;
  logic [3:0]   round4, round6, round8;

  aes_inv_key_sched #(.NK(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .start(start4), .key_in(key4),
    .busy(busy4), .rk_valid(valid4), .rk_ready(rk_ready), .rk_out(out4), .rk_round(round4), .done(done4));
  aes_inv_key_sched #(.NK(6)) u_dut6 (.clk(clk), .rst_n(rst_n), .start(start6), .key_in(key6),
    .busy(busy6), .rk_valid(valid6), .rk_ready(rk_ready), .rk_out(out6), .rk_round(round6), .done(done6));
  aes_inv_key_sched #(.NK(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .key_in(key8),
    .busy(busy8), .rk_valid(valid8), .rk_ready(rk_ready), .rk_out(out8), .rk_round(round8), .done(done8));

  int           cur = 4;
  logic         s_busy, s_valid, s_done;
  logic [127:0] s_out;
  logic [3:0]   s_round;

  always_comb begin
    case (cur)
      4:       begin s_busy = busy4; s_valid = valid4; s_done = done4; s_out = out4; s_round = round4; end
      6:       begin s_busy = busy6; s_valid = valid6; s_done = done6; s_out = out6; s_round = round6; end
      default: begin s_busy = busy8; s_valid = valid8; s_done = done8; s_out = out8; s_round = round8; end
    endcase
  end

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] sbox_t [256];

  localparam logic [255:0] K4 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K6 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R9_RAW = 128'hac7766f319fadc2128d12941575c006e;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] acc, p;
    acc = 8'h00;
    p   = x;
    for (int k = 0; k < 8; k++) begin
      if (z[k]) acc ^= p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  function automatic logic [7:0] rc_tb(input int n);
    logic [7:0] v;
    v = 8'h01;
    for (int k = 1; k < n; k++) v = gm(v, 8'h02);
    return v;
  endfunction

  function automatic logic [127:0] invmix_tb(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = x[127-32*c -: 32];
      y[127-32*c -: 32] = {gm(a0,8'd14)^gm(a1,8'd11)^gm(a2,8'd13)^gm(a3,8'd9),
                           gm(a0,8'd9)^gm(a1,8'd14)^gm(a2,8'd11)^gm(a3,8'd13),
                           gm(a0,8'd13)^gm(a1,8'd9)^gm(a2,8'd14)^gm(a3,8'd11),
                           gm(a0,8'd11)^gm(a1,8'd13)^gm(a2,8'd9)^gm(a3,8'd14)};
    end
    return y;
  endfunction

  // Full forward expansion, then round keys queued in the order the DUT must emit them.
  task automatic load_model(input int nk, input logic [255:0] key);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [127:0] k;
    exp_t         e;
    int           nr;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc_tb(i / nk), 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    sb.delete();
    for (int rr = nr; rr >= 0; rr--) begin
      k = {w[4*rr], w[4*rr+1], w[4*rr+2], w[4*rr+3]};
`ifdef AES_EQ_INV_KEY_EN
      if (rr != 0 && rr != nr) k = invmix_tb(k);
`endif
      e.rnd = 4'(rr);
      e.key = k;
      sb.push_back(e);
    end
  endtask

  task automatic drive_start(input int nk, input logic v);
    case (nk)
      4:       start4 = v;
      6:       start6 = v;
      default: start8 = v;
    endcase
  endtask

  task automatic run_seq(input int nk, input logic [255:0] key, input logic [127:0] first_lit,
                         input int ready_pct, input int abort_after);
    exp_t         e;
    int           hs, dones, nr;
    logic         finished, prev_stall, first;
    logic [127:0] prev_out, r9_exp;
    logic [3:0]   prev_round;
    nr = nk + 6;
    hs = 0; dones = 0; finished = 1'b0; prev_stall = 1'b0; first = 1'b1;
    prev_out = '0; prev_round = '0;
    r9_exp = R9_RAW;
`ifdef AES_EQ_INV_KEY_EN
    r9_exp = invmix_tb(R9_RAW);
`endif
    cur = nk;
    load_model(nk, key);
    @(negedge clk);
    key4 = key[255:128]; key6 = key[255:64]; key8 = key;
    rk_ready = 1'b0;
    drive_start(nk, 1'b1);
    @(negedge clk);
    drive_start(nk, 1'b0);
    #1 chk("busy_after_start", 256'(s_busy), 256'(1));
    for (int cyc = 1; cyc < 3000; cyc++) begin
      rk_ready = ($urandom_range(0, 99) < ready_pct);
      drive_start(nk, cyc == 10);
      #1;
      if (s_done) dones++;
      if (prev_stall) begin
        chk("hold_valid", 256'(s_valid), 256'(1));
        chk("hold_out", 256'(s_out), 256'(prev_out));
        chk("hold_round", 256'(s_round), 256'(prev_round));
      end
      if (s_valid && rk_ready) begin
        if (sb.size() == 0) begin
          chk("extra_key", 256'(0), 256'(1));
          break;
        end
        e = sb.pop_front();
        hs++;
        chk("rk_round", 256'(s_round), 256'(e.rnd));
        chk("rk_out", 256'(s_out), 256'(e.key));
        chk("done_flag", 256'(s_done), 256'(e.rnd == 4'd0));
        if (first) begin
          chk("first_rk_literal", 256'(s_out), 256'(first_lit));
          if (nk == 4 && ready_pct == 100) chk("first_latency", 256'(cyc), 256'(41));
          first = 1'b0;
        end
        if (nk == 4 && e.rnd == 4'd9) chk("r9_literal", 256'(s_out), 256'(r9_exp));
        if (e.rnd == 4'd0) begin
          chk("r0_is_key", 256'(s_out), 256'(key[255:128]));
          drive_start(nk, 1'b1);
          finished = 1'b1;
          break;
        end
        if (hs == abort_after) break;
      end
      prev_stall = s_valid && !rk_ready;
      prev_out   = s_out;
      prev_round = s_round;
      @(negedge clk);
    end
    if (abort_after < 0) begin
      chk("finished_in_budget", 256'(finished), 256'(1));
      @(negedge clk);
      drive_start(nk, 1'b0);
      rk_ready = 1'b0;
      #1;
      chk("idle_busy", 256'(s_busy), 256'(0));
      chk("idle_valid", 256'(s_valid), 256'(0));
      chk("handshakes", 256'(hs), 256'(nr + 1));
      chk("done_pulses", 256'(dones), 256'(1));
    end else begin
      chk("abort_handshakes", 256'(hs), 256'(abort_after));
      rk_ready = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_t[x] = s;
    end

    rst_n = 1'b0; rk_ready = 1'b0;
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    key4 = '0; key6 = '0; key8 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 256'(busy4), 256'(0));
    chk("rst_valid", 256'(valid4), 256'(0));
    chk("rst_done", 256'(done4), 256'(0));
    chk("rst_out", 256'(out4), 256'(0));
    chk("rst_round", 256'(round4), 256'(0));
    chk("rst_valid8", 256'(valid8), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_seq(4, K4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 100, -1);
    run_seq(6, K6, 128'he98ba06f448c773c8ecc720401002202, 100, -1);
    run_seq(8, K8, 128'hfe4890d1e6188d0b046df344706c631e, 100, -1);
    run_seq(4, K4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 30, -1);
    run_seq(6, K6, 128'he98ba06f448c773c8ecc720401002202, 30, -1);
    run_seq(8, K8, 128'hfe4890d1e6188d0b046df344706c631e, 30, -1);

    // Abort after round 7 is accepted, then restart from scratch.
    run_seq(4, K4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 100, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 256'(busy4), 256'(0));
    chk("abort_valid", 256'(valid4), 256'(0));
    chk("abort_done", 256'(done4), 256'(0));
    chk("abort_out", 256'(out4), 256'(0));
    chk("abort_round", 256'(round4), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(4, K4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 100, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
